pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The parameter list SHALL be: CNT_W, default 16, width of the statistics counters (used only when HAZARD_STATS_EN is defined).
REQ-002 Port list SHALL be, in order: name, direction, width, meaning (clock and reset first):
- Clk  in  1  single clock; all state changes on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- RsIn  in  5  decode-stage source register rs.
- RtIn  in  5  decode-stage source register rt.
- UsesRsIn  in  1  decode-stage instruction reads rs.
- UsesRtIn  in  1  decode-stage instruction reads rt.
- ExMemReadIn  in  1  DEC/EX register holds a load.
- ExRegDstIn  in  5  DEC/EX destination register.
- ExRegWriteIn  in  1  DEC/EX instruction writes the register file.
- ExBranchTakenIn  in  1  EX resolved a taken branch.
- ExJumpIn  in  1  EX holds j/jal/jr.
- MemBusyIn  in  1  memory stage not ready; the whole pipeline must freeze.
- PCWriteOut  out  1  PC load enable.
- IFIDWriteOut  out  1  IF/ID load enable.
- IFIDFlushOut  out  1  IF/ID loads a NOP.
- IDEXWriteOut  out  1  DEC/EX load enable.
- IDEXBubbleOut  out  1  DEC/EX loads all-zero control signals.
- StateOut  out  2  current FSM state.
- StallCountOut  out  CNT_W  load-use stalls taken (HAZARD_STATS_EN only).
- FlushCountOut  out  CNT_W  flushes taken (HAZARD_STATS_EN only).

Function
REQ-003 Define Hazard = ExMemReadIn & ExRegWriteIn & (ExRegDstIn != 0) & ((UsesRsIn & RsIn == ExRegDstIn) | (UsesRtIn & RtIn == ExRegDstIn)).
REQ-004 Define Redirect = ExBranchTakenIn | ExJumpIn | PendFlush.
REQ-005 Outputs SHALL be combinational from inputs and PendFlush (zero latency), and SHALL use this priority: Freeze > Flush > Stall > Run.
REQ-006 Freeze (MemBusyIn=1): PCWriteOut=0, IFIDWriteOut=0, IDEXWriteOut=0, IFIDFlushOut=0, IDEXBubbleOut=0.
REQ-007 Flush (Redirect=1, not frozen): PCWriteOut=1, IFIDWriteOut=1, IDEXWriteOut=1, IFIDFlushOut=1, IDEXBubbleOut=1.
REQ-008 Stall (Hazard=1, not frozen, no Redirect): PCWriteOut=0, IFIDWriteOut=0, IDEXWriteOut=1, IDEXBubbleOut=1, IFIDFlushOut=0.
REQ-009 Run: all write enables 1, both flush/bubble outputs 0.
REQ-010 PendFlush SHALL set on a posedge where MemBusyIn=1 and (ExBranchTakenIn|ExJumpIn)=1; it SHALL clear on the first posedge where MemBusyIn=0; it is never set outside Freeze.
REQ-011 FSM states: RUN=2'b00, STALL=2'b01, FLUSH=2'b10, FREEZE=2'b11; the registered next state SHALL equal the action selected this cycle; StateOut SHALL present the registered state.
REQ-012 A load-use stall SHALL last exactly one cycle per hazard, because the bubble clears ExMemReadIn; back-to-back Hazard cycles SHALL each stall.
REQ-013 A Redirect coincident with Hazard SHALL flush only; no stall.
REQ-014 Register 0 SHALL never cause a stall.

Reset
REQ-015 While Rst_n=0: state=RUN, PendFlush=0, counters=0; outputs follow REQ-005..009 with PendFlush=0.
REQ-016 Reset asserted mid-Freeze SHALL discard PendFlush; the first cycle after release SHALL evaluate inputs fresh.

Configuration
REQ-017 Macro HAZARD_STATS_EN: when defined, StallCountOut/FlushCountOut SHALL increment on each posedge in Stall/Flush action, saturating at all-ones; when undefined, the counters SHALL not exist and both ports SHALL be tied to 0.

Structure
REQ-018 A shared package SHALL hold the state encoding constants (RUN/STALL/FLUSH/FREEZE) and the REG_ZERO constant.
REQ-019 One sub-module, hazard_cmp, SHALL implement the REQ-003 comparison combinationally; the top level holds the FSM, PendFlush and counters.

Verification
REQ-020 The bench SHALL cover:
- Load $8 in EX, decode reads rs=$8 -> one cycle PCWriteOut=0, IDEXBubbleOut=1, then RUN; StallCountOut=1.
- Load $0 in EX, decode reads rs=$0 -> no stall.
- Taken branch in EX coincident with Hazard -> IFIDFlushOut=1, IDEXBubbleOut=1, PCWriteOut=1; StateOut=FLUSH next cycle.
- MemBusyIn=1 for 3 cycles with ExJumpIn pulsed in cycle 1 -> 3 cycles of all enables 0, then a flush cycle; FlushCountOut=1.
- Rst_n low during Freeze with PendFlush=1 -> after release no flush; StateOut=RUN.
- CNT_W=2 and 5 stalls -> StallCountOut=3 (saturated); built without HAZARD_STATS_EN -> StallCountOut reads 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encoding and register constants for the hazard controller
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// rtl/pipe_hazard_ctrl_hazard_cmp.sv - combinational load-use hazard detector (decode sources vs EX load dest)
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic       ex_reg_write_i,
  input  logic [4:0] ex_reg_dst_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rs_i,
  input  logic       uses_rt_i,
  output logic       hazard_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = uses_rs_i && (rs_i == ex_reg_dst_i);
  assign rt_match = uses_rt_i && (rt_i == ex_reg_dst_i);

  // $zero is hardwired, so a load targeting it can never feed a consumer
  assign hazard_o = ex_mem_read_i && ex_reg_write_i && (ex_reg_dst_i != REG_ZERO)
                    && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze/flush/stall controller; HAZARD_STATS_EN adds stall/flush counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       RsIn,
  input  logic [4:0]       RtIn,
  input  logic             UsesRsIn,
  input  logic             UsesRtIn,
  input  logic             ExMemReadIn,
  input  logic [4:0]       ExRegDstIn,
  input  logic             ExRegWriteIn,
  input  logic             ExBranchTakenIn,
  input  logic             ExJumpIn,
  input  logic             MemBusyIn,
  output logic             PCWriteOut,
  output logic             IFIDWriteOut,
  output logic             IFIDFlushOut,
  output logic             IDEXWriteOut,
  output logic             IDEXBubbleOut,
  output logic [1:0]       StateOut,
  output logic [CNT_W-1:0] StallCountOut,
  output logic [CNT_W-1:0] FlushCountOut
);

  hz_state_e state_q, state_d;
  logic      pend_flush_q, pend_flush_d;
  logic      hazard;
  logic      redirect;

  hazard_cmp u_hazard_cmp (
    .ex_mem_read_i (ExMemReadIn),
    .ex_reg_write_i(ExRegWriteIn),
    .ex_reg_dst_i  (ExRegDstIn),
    .rs_i          (RsIn),
    .rt_i          (RtIn),
    .uses_rs_i     (UsesRsIn),
    .uses_rt_i     (UsesRtIn),
    .hazard_o      (hazard)
  );

  assign redirect = ExBranchTakenIn || ExJumpIn || pend_flush_q;

  // A redirect seen while frozen is remembered and replayed once memory releases
  assign pend_flush_d = MemBusyIn ? (pend_flush_q || ExBranchTakenIn || ExJumpIn) : 1'b0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= RUN;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (MemBusyIn)     state_d = FREEZE;
    else if (redirect) state_d = FLUSH;
    else if (hazard)   state_d = STALL;
  end

  always_comb begin
    PCWriteOut    = 1'b1;
    IFIDWriteOut  = 1'b1;
    IDEXWriteOut  = 1'b1;
    IFIDFlushOut  = 1'b0;
    IDEXBubbleOut = 1'b0;
    unique case (state_d)
      FREEZE: begin
        PCWriteOut   = 1'b0;
        IFIDWriteOut = 1'b0;
        IDEXWriteOut = 1'b0;
      end
      FLUSH: begin
        IFIDFlushOut  = 1'b1;
        IDEXBubbleOut = 1'b1;
      end
      STALL: begin
        PCWriteOut    = 1'b0;
        IFIDWriteOut  = 1'b0;
        IDEXBubbleOut = 1'b1;
      end
      default: ;
    endcase
  end

  assign StateOut = state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_d == STALL && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_d == FLUSH && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCountOut = stall_cnt_q;
  assign FlushCountOut = flush_cnt_q;
`else
  assign StallCountOut = '0;
  assign FlushCountOut = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rs = '0, rt = '0, ex_dst = '0;
  logic             uses_rs = 0, uses_rt = 0, ex_mr = 0, ex_rw = 0, ex_br = 0, ex_jmp = 0, mem_busy = 0;
  logic             pc_we, ifid_we, ifid_flush, idex_we, idex_bubble;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  int m_state = 0;
  bit m_pend = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk            (clk),
    .Rst_n          (rst_n),
    .RsIn           (rs),
    .RtIn           (rt),
    .UsesRsIn       (uses_rs),
    .UsesRtIn       (uses_rt),
    .ExMemReadIn    (ex_mr),
    .ExRegDstIn     (ex_dst),
    .ExRegWriteIn   (ex_rw),
    .ExBranchTakenIn(ex_br),
    .ExJumpIn       (ex_jmp),
    .MemBusyIn      (mem_busy),
    .PCWriteOut     (pc_we),
    .IFIDWriteOut   (ifid_we),
    .IFIDFlushOut   (ifid_flush),
    .IDEXWriteOut   (idex_we),
    .IDEXBubbleOut  (idex_bubble),
    .StateOut       (state_o),
    .StallCountOut  (stall_cnt),
    .FlushCountOut  (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 run, 1 stall, 2 flush, 3 freeze
  function automatic int pick_action();
    bit haz;
    haz = ex_mr && ex_rw && (ex_dst != 0) &&
          ((uses_rs && rs == ex_dst) || (uses_rt && rt == ex_dst));
    if (mem_busy) return 3;
    if (ex_br || ex_jmp || m_pend) return 2;
    if (haz) return 1;
    return 0;
  endfunction

  // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXBubble}
  function automatic logic [4:0] expect_ctrl(input int act);
    case (act)
      3:       return 5'b00000;
      2:       return 5'b11111;
      1:       return 5'b00101;
      default: return 5'b11100;
    endcase
  endfunction

  task automatic cycle(input string tag, input bit rn,
                       input logic [4:0] i_rs, input logic [4:0] i_rt, input bit i_urs, input bit i_urt,
                       input bit i_mr, input logic [4:0] i_dst, input bit i_rw,
                       input bit i_br, input bit i_jmp, input bit i_mb);
    int act;
    @(negedge clk);
    rst_n = rn; rs = i_rs; rt = i_rt; uses_rs = i_urs; uses_rt = i_urt;
    ex_mr = i_mr; ex_dst = i_dst; ex_rw = i_rw; ex_br = i_br; ex_jmp = i_jmp; mem_busy = i_mb;
    if (!rn) begin
      m_state = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
    end
    #1;
    act = pick_action();
    check({tag, "_ctrl"}, {27'd0, pc_we, ifid_we, idex_we, ifid_flush, idex_bubble}, {27'd0, expect_ctrl(act)});
    check({tag, "_state"}, {30'd0, state_o}, m_state);
`ifdef HAZARD_STATS_EN
    check({tag, "_stallcnt"}, {30'd0, stall_cnt}, m_stalls);
    check({tag, "_flushcnt"}, {30'd0, flush_cnt}, m_flushes);
`else
    check({tag, "_stallcnt"}, {30'd0, stall_cnt}, 0);
    check({tag, "_flushcnt"}, {30'd0, flush_cnt}, 0);
`endif
    if (rn) begin
      m_state = act;
      m_pend = i_mb ? (m_pend || i_br || i_jmp) : 1'b0;
      if (act == 1 && m_stalls < CNT_MAX) m_stalls++;
      if (act == 2 && m_flushes < CNT_MAX) m_flushes++;
    end
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    cycle("rst0", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    check("rst_state", {30'd0, state_o}, 0);
    check("rst_pcwe", {31'd0, pc_we}, 1);
    cycle("rst1", 0, 5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 0, 0, 0);
    idle("rel");

    cycle("ld8", 1, 5'd8, 5'd3, 1, 0, 1, 5'd8, 1, 0, 0, 0);
    check("ld8_pcwe", {31'd0, pc_we}, 0);
    check("ld8_bubble", {31'd0, idex_bubble}, 1);
    idle("ld8_after");
    check("ld8_state_stall", {30'd0, state_o}, 1);
    check("ld8_pcwe_after", {31'd0, pc_we}, 1);
    idle("ld8_run");
    check("ld8_state_run", {30'd0, state_o}, 0);

    cycle("ld0", 1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0, 0, 0);
    check("ld0_pcwe", {31'd0, pc_we}, 1);
    cycle("ldrt", 1, 5'd1, 5'd9, 0, 1, 1, 5'd9, 1, 0, 0, 0);

    cycle("brhaz", 1, 5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 1, 0, 0);
    check("brhaz_flush", {29'd0, ifid_flush, idex_bubble, pc_we}, 3'b111);
    idle("brhaz_after");
    check("brhaz_state", {30'd0, state_o}, 2);

    cycle("frz1", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 1);
    cycle("frz2", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    cycle("frz3", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    check("frz3_en", {29'd0, pc_we, ifid_we, idex_we}, 3'b000);
    idle("frz_release");
    check("frz_release_flush", {31'd0, ifid_flush}, 1);
    idle("frz_done");
    check("frz_state_flush", {30'd0, state_o}, 2);

    cycle("rfz1", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1);
    cycle("rfz2", 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    cycle("rfz_rst", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    idle("rfz_rel");
    check("rfz_noflush", {31'd0, ifid_flush}, 0);
    idle("rfz_after");
    check("rfz_state", {30'd0, state_o}, 0);

    for (int i = 0; i < 5; i++) cycle("stall5", 1, 5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 0);
    idle("stall5_done");
`ifdef HAZARD_STATS_EN
    check("stall5_sat", {30'd0, stall_cnt}, 3);
`else
    check("stall5_zero", {30'd0, stall_cnt}, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      cycle("rnd", ($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
